bch_decode_ctrl: RTL and testbench

Sequencing controller for the BCH(63,56) single-error-correcting decoder. Accepts one 63-bit received word per transaction over a valid/ready handshake and starts the syndrome unit. Depending on syndrome and weight, it either drives the syndrome-to-error-pattern lookup stage or bypasses it. It then applies the correction and returns 56 data bits with status flags and running statistics.

---
 rtl/bch_pkg.sv | 33 +++
 rtl/bch_decode_ctrl_if.sv | 43 ++++
 rtl/bch_stat_cnt.sv | 21 ++
 rtl/bch_decode_ctrl.sv | 154 +++++++++++++++
 tb/tb_bch_decode_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH(63,56) decode controller.
// Holds the code geometry, FSM states and the codeword data slice helper.
package bch_pkg;

  localparam int N        = 63;
  localparam int K        = 56;
  localparam int R        = 7;
  localparam int DATA_MSB = N - 1;
  localparam int DATA_LSB = R;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SSTART,
    ST_SWAIT,
    ST_LEN,
    ST_LWAIT,
    ST_CORR,
    ST_OUT
  } state_t;

  // Outcome class decided before CORR; selects which flag gets raised.
  typedef enum logic [1:0] {
    K_CLEAN,
    K_PERR,
    K_LOOK,
    K_TMO
  } kind_t;

  function automatic logic [K-1:0] data_of(input logic [N-1:0] cw);
    return cw[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/bch_decode_ctrl_if.sv
// Bundle of the word handshake, syndrome unit, lookup stage and result ports.
// master = controller view, slave = surrounding datapath / environment view.
interface bch_decode_ctrl_if;
  import bch_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_cw;
  logic           syn_start;
  logic [N-1:0]   syn_cw;
  logic           syn_done;
  logic [R-1:0]   syn_s;
  logic [2:0]     syn_w;
  logic           lk_en;
  logic [R-1:0]   lk_s;
  logic [2:0]     lk_w;
  logic [N-1:0]   lk_ep;
  logic           lk_done;
  logic           out_valid;
  logic           out_ready;
  logic [K-1:0]   out_data;
  logic           out_corr;
  logic           out_perr;
  logic           out_uncorr;
  logic           out_tmo;
  logic [15:0]    cnt_corr;
  logic [15:0]    cnt_uncorr;

  // lk_done is sticky, so the controller sequences on a latency count and never reads it.
  modport master (
    input  in_valid, in_cw, syn_done, syn_s, syn_w, lk_ep, out_ready,
    output in_ready, syn_start, syn_cw, lk_en, lk_s, lk_w,
           out_valid, out_data, out_corr, out_perr, out_uncorr, out_tmo,
           cnt_corr, cnt_uncorr
  );

  modport slave (
    output in_valid, in_cw, syn_done, syn_s, syn_w, lk_ep, lk_done, out_ready,
    input  in_ready, syn_start, syn_cw, lk_en, lk_s, lk_w,
           out_valid, out_data, out_corr, out_perr, out_uncorr, out_tmo,
           cnt_corr, cnt_uncorr
  );
endinterface

// File: rtl/bch_stat_cnt.sv
// 16-bit saturating event counter; rst_n acts as its synchronous clear.
module bch_stat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/bch_decode_ctrl.sv
// Sequencing controller for the BCH(63,56) single-error-correcting decoder:
// accept word, run syndrome unit, optionally drive lookup, correct, report.
module bch_decode_ctrl
  import bch_pkg::*;
#(
  parameter int SYND_TIMEOUT = 15,
  parameter int LK_LAT       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  bch_decode_ctrl_if.master bus
);

  localparam int TW = $clog2(SYND_TIMEOUT + 1);

  state_t         r_state;
  state_t         w_state_next;
  kind_t          r_kind;
  logic           r_in_ready;
  logic [N-1:0]   r_cw;
  logic [R-1:0]   r_s;
  logic [2:0]     r_w;
  logic [N-1:0]   r_ep;
  logic [TW-1:0]  r_tmo_cnt;
  logic [2:0]     r_lat_cnt;
  logic [K-1:0]   r_data;
  logic           r_corr;
  logic           r_perr;
  logic           r_uncorr;
  logic           r_tmo;
  logic           w_hs;
  logic           w_tmo_hit;
  logic           w_lat_hit;
  logic           w_bypass;
  logic           w_ep_nz;
  logic           w_inc_corr;
  logic           w_inc_uncorr;

  assign w_tmo_hit = (r_tmo_cnt == TW'(SYND_TIMEOUT - 1));
  assign w_lat_hit = (r_lat_cnt == 3'(LK_LAT - 1));
  assign w_bypass  = (bus.syn_s == '0) || (bus.syn_w <= 3'd1);
  assign w_ep_nz   = |r_ep;

  always_comb begin
    w_state_next = r_state;
    w_hs         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_hs         = 1'b1;
          w_state_next = ST_SSTART;
        end
      end
      ST_SSTART: w_state_next = ST_SWAIT;
      ST_SWAIT: begin
        // A syn_done coinciding with the last allowed cycle beats the timeout.
        if (bus.syn_done) begin
          w_state_next = w_bypass ? ST_CORR : ST_LEN;
        end else if (w_tmo_hit) begin
          w_state_next = ST_CORR;
        end
      end
      ST_LEN:   w_state_next = ST_LWAIT;
      ST_LWAIT: if (w_lat_hit) w_state_next = ST_CORR;
      ST_CORR:  w_state_next = ST_OUT;
      ST_OUT:   if (bus.out_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_kind     <= K_CLEAN;
      r_in_ready <= 1'b0;
      r_cw       <= '0;
      r_s        <= '0;
      r_w        <= '0;
      r_ep       <= '0;
      r_tmo_cnt  <= '0;
      r_lat_cnt  <= '0;
      r_data     <= '0;
      r_corr     <= 1'b0;
      r_perr     <= 1'b0;
      r_uncorr   <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == ST_IDLE);
      case (r_state)
        ST_IDLE:   if (w_hs) r_cw <= bus.in_cw;
        ST_SSTART: r_tmo_cnt <= '0;
        ST_SWAIT: begin
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
          if (bus.syn_done) begin
            r_s    <= bus.syn_s;
            r_w    <= bus.syn_w;
            r_ep   <= '0;
            r_kind <= (bus.syn_s == '0) ? K_CLEAN : ((bus.syn_w <= 3'd1) ? K_PERR : K_LOOK);
          end else if (w_tmo_hit) begin
            r_ep   <= '0;
            r_kind <= K_TMO;
          end
        end
        ST_LEN: r_lat_cnt <= '0;
        ST_LWAIT: begin
          // lk_ep is only trusted on the sample cycle; it is stale at all other times.
          r_lat_cnt <= r_lat_cnt + 3'd1;
          if (w_lat_hit) r_ep <= bus.lk_ep;
        end
        ST_CORR: begin
          r_data   <= data_of(r_cw) ^ data_of(r_ep);
          r_corr   <= (r_kind == K_LOOK) && w_ep_nz;
          r_uncorr <= (r_kind == K_LOOK) && !w_ep_nz;
          r_perr   <= (r_kind == K_PERR);
          r_tmo    <= (r_kind == K_TMO);
        end
        default: ;
      endcase
    end
  end

  assign w_inc_corr   = (r_state == ST_CORR) && (r_kind == K_LOOK) && w_ep_nz;
  assign w_inc_uncorr = (r_state == ST_CORR) &&
                        (((r_kind == K_LOOK) && !w_ep_nz) || (r_kind == K_TMO));

  bch_stat_cnt u_cnt_corr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_inc_corr),
    .o_cnt (bus.cnt_corr)
  );

  bch_stat_cnt u_cnt_uncorr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_inc_uncorr),
    .o_cnt (bus.cnt_uncorr)
  );

  assign bus.in_ready   = r_in_ready;
  assign bus.syn_start  = (r_state == ST_SSTART);
  assign bus.syn_cw     = r_cw;
  assign bus.lk_en      = (r_state == ST_LEN);
  assign bus.lk_s       = r_s;
  assign bus.lk_w       = r_w;
  assign bus.out_valid  = (r_state == ST_OUT);
  assign bus.out_data   = r_data;
  assign bus.out_corr   = r_corr;
  assign bus.out_perr   = r_perr;
  assign bus.out_uncorr = r_uncorr;
  assign bus.out_tmo    = r_tmo;

endmodule

// File: tb/tb_bch_decode_ctrl.sv
// Self-checking bench for bch_decode_ctrl: directed vector table plus random
// words scored against a rule-level reference model.
module tb_bch_decode_ctrl;
  import bch_pkg::*;

  localparam int ST = 15;
  localparam int LL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bch_decode_ctrl_if bus();

  bch_decode_ctrl #(.SYND_TIMEOUT(ST), .LK_LAT(LL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [62:0] cw;
    int          k;
    logic [6:0]  s;
    logic [62:0] ep;
    bit          withhold;
    int          bp;
    int          rst_at;
    logic [55:0] exp_data;
    logic [3:0]  exp_flags;   // {corr, perr, uncorr, tmo}
    int          exp_tov;
    bit          exp_lk;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int exp_cc = 0;
  int exp_cu = 0;
  int txn_id = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [62:0] rnd63();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[62:0];
  endfunction

  // Reference model: outcome and result timing straight from the decode rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   w;
    r = v;
    w = $countones(v.s);
    r.exp_data = v.cw[62:7];
    r.exp_lk   = 1'b0;
    if (v.withhold || v.k >= ST) begin
      r.exp_flags = 4'b0001;
      r.exp_tov   = 3 + ST;
    end else if (v.s == 7'd0) begin
      r.exp_flags = 4'b0000;
      r.exp_tov   = 4 + v.k;
    end else if (w <= 1) begin
      r.exp_flags = 4'b0100;
      r.exp_tov   = 4 + v.k;
    end else begin
      r.exp_lk    = 1'b1;
      r.exp_tov   = 5 + v.k + LL;
      r.exp_flags = (v.ep == 63'd0) ? 4'b0010 : 4'b1000;
      r.exp_data  = v.cw[62:7] ^ v.ep[62:7];
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int          t_ov = -1;
    int          acc = -1;
    int          t_lk = -1;
    int          lk_cnt = 0;
    int          bp_left = v.bp;
    bit          bad_ready = 1'b0;
    bit          bad_hold = 1'b0;
    bit          done_rst = 1'b0;
    logic [55:0] held_data = '0;
    logic [3:0]  held_flags = '0;
    logic [3:0]  flags;
    for (int c = 0; c < 80 + v.bp; c++) begin
      @(negedge clk);
      flags = {bus.out_corr, bus.out_perr, bus.out_uncorr, bus.out_tmo};
      if (v.rst_at >= 0 && c == v.rst_at + 1) begin
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_counters", {32'd0, bus.cnt_corr, bus.cnt_uncorr}, 64'd0);
        rst_n  = 1'b1;
        exp_cc = 0;
        exp_cu = 0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        done_rst = 1'b1;
        break;
      end
      if (acc >= 0 && c == acc + 1) begin
        chk("in_ready_after_accept", 64'(bus.in_ready), 64'd1);
        break;
      end
      if (c == 0) chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
      if (c == 1) chk("syn_start", 64'(bus.syn_start), 64'd1);
      if (c >= 1 && bus.in_ready) bad_ready = 1'b1;
      if (bus.lk_en) begin
        lk_cnt++;
        t_lk = c;
        chk("lk_s", 64'(bus.lk_s), 64'(v.s));
        chk("lk_w", 64'(bus.lk_w), 64'($countones(v.s)));
      end
      if (c == v.rst_at) rst_n = 1'b0;
      bus.in_valid = (c == 0);
      bus.in_cw    = (c == 0) ? v.cw : rnd63();
      if (!v.withhold && c == 2 + v.k) begin
        bus.syn_done = 1'b1;
        bus.syn_s    = v.s;
        bus.syn_w    = 3'($countones(v.s));
      end else begin
        bus.syn_done = 1'b0;
        bus.syn_s    = 7'($urandom);
        bus.syn_w    = 3'($urandom);
      end
      bus.lk_ep = (t_lk >= 0 && c >= t_lk + LL) ? v.ep : rnd63();
      if (bus.out_valid) begin
        if (t_ov < 0) begin
          t_ov = c;
          if (v.exp_flags[3]) exp_cc++;
          if (v.exp_flags[1] || v.exp_flags[0]) exp_cu++;
          chk("out_valid_cycle", 64'(t_ov), 64'(v.exp_tov));
          chk("out_data", 64'(bus.out_data), 64'(v.exp_data));
          chk("out_flags", 64'(flags), 64'(v.exp_flags));
          chk("cnt_corr", 64'(bus.cnt_corr), 64'(exp_cc));
          chk("cnt_uncorr", 64'(bus.cnt_uncorr), 64'(exp_cu));
          held_data  = bus.out_data;
          held_flags = flags;
        end else if (bus.out_data !== held_data || flags !== held_flags) begin
          bad_hold = 1'b1;
        end
        if (bp_left == 0) begin
          bus.out_ready = 1'b1;
          acc = c;
        end else begin
          bp_left--;
          bus.out_ready = 1'b0;
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
    bus.in_valid  = 1'b0;
    bus.syn_done  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
    if (v.rst_at >= 0) begin
      chk("reset_sequence_reached", 64'(done_rst), 64'd1);
    end else begin
      chk("out_accepted", 64'(acc >= 0), 64'd1);
      chk("in_ready_busy_low", 64'(bad_ready), 64'd0);
      chk("lk_en_pulses", 64'(lk_cnt), 64'(v.exp_lk));
      if (v.bp > 0) chk("out_stable_bp", 64'(bad_hold), 64'd0);
    end
    $display("txn %0d cw=%h k=%0d s=%b ep=%h exp_flags=%b exp_data=%h tov=%0d",
             txn_id, v.cw, v.k, v.s, v.ep, v.exp_flags, v.exp_data, t_ov);
    txn_id++;
  endtask

  vec_t dv[9];
  vec_t rv;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_cw     = '0;
    bus.syn_done  = 1'b0;
    bus.syn_s     = '0;
    bus.syn_w     = '0;
    bus.lk_ep     = '0;
    bus.lk_done   = 1'b0;
    bus.out_ready = 1'b0;

    dv[0] = '{cw: 63'h0, k: 1, s: 7'b0000000, ep: 63'h0, withhold: 1'b0, bp: 0, rst_at: -1,
              exp_data: 56'h0, exp_flags: 4'b0000, exp_tov: 5, exp_lk: 1'b0};
    dv[1] = '{cw: 63'h4000000000000000, k: 1, s: 7'b1100010, ep: 63'h4000000000000000,
              withhold: 1'b0, bp: 0, rst_at: -1,
              exp_data: 56'h0, exp_flags: 4'b1000, exp_tov: 7, exp_lk: 1'b1};
    dv[2] = '{cw: {56'hA5A55A5A0F0FF0, 7'b0000100}, k: 0, s: 7'b0000100, ep: 63'h0,
              withhold: 1'b0, bp: 0, rst_at: -1,
              exp_data: 56'hA5A55A5A0F0FF0, exp_flags: 4'b0100, exp_tov: 4, exp_lk: 1'b0};
    dv[3] = '{cw: {56'h123456789ABCDE, 7'h55}, k: 2, s: 7'b1000011, ep: 63'h0,
              withhold: 1'b0, bp: 0, rst_at: -1,
              exp_data: 56'h123456789ABCDE, exp_flags: 4'b0010, exp_tov: 8, exp_lk: 1'b1};
    dv[4] = '{cw: {56'hDEADBEEF012345, 7'h00}, k: 0, s: 7'b0000000, ep: 63'h0,
              withhold: 1'b1, bp: 0, rst_at: -1,
              exp_data: 56'hDEADBEEF012345, exp_flags: 4'b0001, exp_tov: 18, exp_lk: 1'b0};
    dv[5] = '{cw: {56'hCAFEF00D998877, 7'h00}, k: 14, s: 7'b0000000, ep: 63'h0,
              withhold: 1'b0, bp: 0, rst_at: -1,
              exp_data: 56'hCAFEF00D998877, exp_flags: 4'b0000, exp_tov: 18, exp_lk: 1'b0};
    dv[6] = '{cw: {56'h0F0F0F0F0F2F0F, 7'h00}, k: 3, s: 7'b0110101, ep: 63'h100000,
              withhold: 1'b0, bp: 10, rst_at: -1,
              exp_data: 56'h0F0F0F0F0F0F0F, exp_flags: 4'b1000, exp_tov: 9, exp_lk: 1'b1};
    dv[7] = '{cw: 63'h4000000000000000, k: 1, s: 7'b1100010, ep: 63'h4000000000000000,
              withhold: 1'b0, bp: 0, rst_at: 5,
              exp_data: 56'h0, exp_flags: 4'b0000, exp_tov: 0, exp_lk: 1'b1};
    dv[8] = '{cw: 63'h4000000000000000, k: 1, s: 7'b1100010, ep: 63'h4000000000000000,
              withhold: 1'b0, bp: 0, rst_at: -1,
              exp_data: 56'h0, exp_flags: 4'b1000, exp_tov: 7, exp_lk: 1'b1};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
    chk("reset_strobes", 64'({bus.out_valid, bus.syn_start, bus.lk_en}), 64'd0);
    chk("reset_flags_data", {4'(0), bus.out_corr, bus.out_perr, bus.out_uncorr, bus.out_tmo,
                             bus.out_data}, 64'd0);
    chk("reset_counters", {32'd0, bus.cnt_corr, bus.cnt_uncorr}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 9; i++) run_vec(dv[i]);

    for (int i = 0; i < 40; i++) begin
      int mode;
      rv          = dv[0];
      rv.cw       = rnd63();
      rv.k        = $urandom_range(0, ST + 1);
      rv.bp       = $urandom_range(0, 3);
      rv.rst_at   = -1;
      rv.withhold = 1'b0;
      rv.ep       = 63'h0;
      mode        = $urandom_range(0, 4);
      case (mode)
        0: rv.s = 7'd0;
        1: rv.s = 7'(1 << $urandom_range(0, 6));
        2, 3: begin
          rv.s = 7'($urandom);
          while ($countones(rv.s) < 2) rv.s = 7'($urandom);
          if (mode == 2) rv.ep = 63'(1) << $urandom_range(0, 62);
        end
        default: begin
          rv.s        = 7'($urandom);
          rv.withhold = 1'b1;
        end
      endcase
      run_vec(model(rv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
